serial_parity_sched: RTL and testbench

//   Round-robin scheduler that shares one serial parity engine between NREQ requesters.
//   - Grants one requester at a time and latches its DATA_W-bit word.
//   - Shifts the word out LSB-first, one bit per clock, accumulating running parity.
//   - Reports the final parity bit with the granted requester's id.
//   - Sits between the parallel producers and the serial parity/transmit path.

---
 rtl/serial_parity_sched.sv | 154 +++++++++++++++
 tb/tb_serial_parity_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_sched.sv
// Round-robin scheduler feeding one serial parity engine shared by NREQ
// requesters. A granted word is shifted out LSB-first, one bit per clock,
// and the finished parity is reported together with the requester id.
module serial_parity_sched #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int ODD_PAR = 0,
  localparam int IDW    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*DATA_W-1:0] data_i,
  output logic [NREQ-1:0]        ack_o,
  output logic                   busy_o,
  output logic                   bit_out_o,
  output logic                   bit_valid_o,
  output logic                   done_o,
  output logic                   parity_o,
  output logic [IDW-1:0]         grant_id_o
);

  localparam int             CW       = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_W - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
  localparam logic           PAR_INV  = 1'(ODD_PAR);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                bit_q, bit_d;
  logic                vld_q, vld_d;
  logic                done_q, done_d;
  logic                par_q, par_d;

  logic                found;
  logic [IDW-1:0]      sel;
  logic [DATA_W-1:0]   word;

  // First requester at or after ptr, searching upward with wrap.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = int'(ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req_i[c]) begin
        found = 1'b1;
        sel   = IDW'(c);
      end
    end
  end

  assign word = data_i[int'(sel)*DATA_W +: DATA_W];

  // Next state and next registered outputs; everything holds by default.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ack_d   = '0;
    busy_d  = busy_q;
    bit_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = SHIFT;
          sreg_d     = word;
          gid_d      = sel;
          ack_d[sel] = 1'b1;
          acc_d      = 1'b0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          vld_d      = 1'b1;
          bit_d      = word[0];
        end
      end
      SHIFT: begin
        acc_d  = acc_q ^ sreg_q[0];
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last bit consumed: publish parity including it.
          state_d = DONE;
          done_d  = 1'b1;
          par_d   = acc_q ^ sreg_q[0] ^ PAR_INV;
        end else begin
          vld_d = 1'b1;
          bit_d = sreg_q[1];
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      sreg_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      par_q   <= par_d;
    end
  end

  assign ack_o       = ack_q;
  assign busy_o      = busy_q;
  assign bit_out_o   = bit_q;
  assign bit_valid_o = vld_q;
  assign done_o      = done_q;
  assign parity_o    = par_q;
  assign grant_id_o  = gid_q;

endmodule

// File: tb/tb_serial_parity_sched.sv
// Bench for serial_parity_sched: even- and odd-parity instances run on the
// same stimulus and are checked every cycle against a frame-timeline model,
// plus table-driven single frames and hand-written corner sequences.
module tb_serial_parity_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] data = '0;

  logic [NREQ-1:0] ack0, ack1;
  logic busy0, bo0, bv0, dn0, par0;
  logic busy1, bo1, bv1, dn1, par1;
  logic [1:0] gid0, gid1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_parity_sched #(.NREQ(NREQ), .DATA_W(DW), .ODD_PAR(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(data),
    .ack_o(ack0), .busy_o(busy0), .bit_out_o(bo0), .bit_valid_o(bv0),
    .done_o(dn0), .parity_o(par0), .grant_id_o(gid0));

  serial_parity_sched #(.NREQ(NREQ), .DATA_W(DW), .ODD_PAR(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(data),
    .ack_o(ack1), .busy_o(busy1), .bit_out_o(bo1), .bit_valid_o(bv1),
    .done_o(dn1), .parity_o(par1), .grant_id_o(gid1));

  // Model: ph = position within a frame (0 idle, 1..DW shift, DW+1 done).
  int         ph = 0, mg = 0, mptr = 0;
  logic [7:0] mw = '0;
  logic       mpar0 = 1'b0, mpar1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      ph = 0; mptr = 0; mg = 0; mw = '0; mpar0 = 1'b0; mpar1 = 1'b0;
    end else if (ph == 0) begin
      if (req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (mptr + k) % NREQ;
          if (req[c]) begin mg = c; break; end
        end
        mw = data[mg*DW +: DW];
        ph = 1;
      end
    end else if (ph < DW) begin
      ph++;
    end else if (ph == DW) begin
      ph = DW + 1;
      mpar0 = ($countones(mw) % 2) == 1;
      mpar1 = !mpar0;
    end else begin
      ph = 0;
      mptr = (mg + 1) % NREQ;
    end
  endtask

  function automatic logic [10:0] expv(input logic odd);
    logic [3:0] a;
    logic v, b;
    a = (ph == 1) ? 4'(1 << mg) : 4'b0;
    v = (ph >= 1 && ph <= DW);
    b = v ? mw[ph-1] : 1'b0;
    return {a, ph != 0, b, v, ph == DW + 1, odd ? mpar1 : mpar0, 2'(mg)};
  endfunction

  // One clock: advance the model with pre-edge inputs, then compare after the edge.
  task automatic step();
    model_update();
    @(posedge clk); #1;
    chk("cycle_even", {21'b0, ack0, busy0, bo0, bv0, dn0, par0, gid0}, {21'b0, expv(1'b0)});
    chk("cycle_odd",  {21'b0, ack1, busy1, bo1, bv1, dn1, par1, gid1}, {21'b0, expv(1'b1)});
  endtask

  // Step until done pulses on the even instance; returns cycles taken.
  task automatic run_to_done(input string name, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (dn0) break;
      if (n > 40) begin
        chk({name, "_timeout"}, 32'(n), 32'(DW + 1));
        break;
      end
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] w;
    logic       pe;
    logic       po;
  } vec_t;

  vec_t tbl[6];
  int n, prev_t;
  logic [7:0] bits;
  logic ack1_seen;

  initial begin
    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1};
    tbl[1] = '{2, 8'hFF, 1'b0, 1'b1};
    tbl[2] = '{3, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{1, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{0, 8'h80, 1'b1, 1'b0};
    tbl[5] = '{3, 8'h7F, 1'b1, 1'b0};

    // Reset held 3 cycles, no requests: everything quiet.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("reset_outs", {21'b0, ack0, busy0, bo0, bv0, dn0, par0, gid0}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) step();
    chk("idle_busy", {31'b0, busy0}, 32'd0);

    // Single frame A5 from requester 0: bits, latency, parity.
    data[0 +: 8] = 8'hA5;
    req = 4'b0001;
    step();
    req = 4'b0000;
    chk("a5_ack", {28'b0, ack0}, 32'h1);
    bits = '0;
    bits[0] = bo0;
    for (int i = 1; i < DW; i++) begin step(); bits[i] = bo0; end
    chk("a5_bits", {24'b0, bits}, 32'hA5);
    step();
    chk("a5_done", {31'b0, dn0}, 32'd1);
    chk("a5_par", {30'b0, par1, par0}, 32'b10);
    step();
    chk("a5_hold_par", {29'b0, gid0, par0}, 32'd0);

    // Table of single-requester frames.
    foreach (tbl[t]) begin
      data = $urandom();
      data[tbl[t].id*DW +: DW] = tbl[t].w;
      req = 4'(1 << tbl[t].id);
      step();
      req = '0;
      run_to_done("tbl", n);
      chk("tbl_latency", 32'(n), 32'(DW));
      chk("tbl_gid", {30'b0, gid0}, 32'(tbl[t].id));
      chk("tbl_par", {30'b0, par1, par0}, {30'b0, tbl[t].po, tbl[t].pe});
      step();
    end

    // Strict rotation with all requests held; restart from reset for ptr=0.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    data = {4{8'h01}};
    req = 4'b1111;
    prev_t = 0;
    for (int f = 0; f < 5; f++) begin
      run_to_done("rot", n);
      chk("rot_gid", {30'b0, gid0}, 32'(f % NREQ));
      chk("rot_par", {31'b0, par0}, 32'd1);
      if (f > 0) chk("rot_period", 32'(n), 32'(DW + 2));
    end
    req = '0;
    step();

    // Mid-frame async reset, then ptr restarts at 0 and finds requester 1.
    data[0 +: 8] = 8'hFF;
    req = 4'b0001;
    step();
    req = '0;
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", {21'b0, ack0, busy0, bo0, bv0, dn0, par0, gid0}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DW + 2; i++) begin
      step();
      chk("abort_nodone", {31'b0, dn0}, 32'd0);
    end
    req = 4'b0010;
    step();
    req = '0;
    chk("after_abort_gid", {30'b0, gid0}, 32'd1);
    run_to_done("abort", n);

    // ptr now 2: req 1001 grants 3 then 0; requester 1 drops before its turn.
    step();
    req = 4'b1001;
    ack1_seen = 1'b0;
    step();
    chk("wrap_first", {30'b0, gid0}, 32'd3);
    req = 4'b1011;
    step(); step();
    req = 4'b1001;
    for (int i = 0; i < 2 * (DW + 2); i++) begin
      step();
      if (ack0[1]) ack1_seen = 1'b1;
      if (dn0) chk("wrap_seq", {30'b0, gid0}, (i < DW + 2) ? 32'd3 : 32'd0);
    end
    chk("drop_no_ack", {31'b0, ack1_seen}, 32'd0);
    req = '0;
    for (int i = 0; i < DW + 2; i++) step();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom());
      if ($urandom_range(0, 1) == 0) data = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
